// File: rtl/fetch_stage_if.sv
// Instruction-memory bus of the fetch stage: single-outstanding request strobe
// plus address, answered later by a valid strobe with the read data.
interface fetch_stage_if #(
  parameter int W = 32
) ();
  logic         ImemReq;
  logic [W-1:0] ImemAddr;
  logic         ImemValid;
  logic [W-1:0] ImemRdata;

  modport master (output ImemReq, output ImemAddr, input ImemValid, input ImemRdata);
  modport slave  (input ImemReq, input ImemAddr, output ImemValid, output ImemRdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32IM instruction fetch: owns PCF, drives the imem bus, holds the IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN halts fetch with FetchFault on a misaligned redirect.
module fetch_stage #(
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_stage_if.master          imem,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic                   PCSrc,
  input  logic [INSTR_WIDTH-1:0] PCTarget,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [INSTR_WIDTH-1:0] PCD,
  output logic [INSTR_WIDTH-1:0] PCPlus4D,
  output logic                   ValidD
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                   FetchFault
`endif
);
  localparam logic [INSTR_WIDTH-1:0] NOP        = INSTR_WIDTH'(32'h0000_0013);
  localparam logic [INSTR_WIDTH-1:0] FOUR       = INSTR_WIDTH'(4);
  localparam logic [INSTR_WIDTH-1:0] ALIGN_MASK = ~INSTR_WIDTH'(3);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_FULL, S_DROP, S_HALT} state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] pcf_q, pcf_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d;
  logic [INSTR_WIDTH-1:0] instr_q, pcd_q, pcp4_q;
  logic                   vld_q;
  logic                   deliver;
  logic                   misalign;
  logic [INSTR_WIDTH-1:0] dword;
  logic [INSTR_WIDTH-1:0] tgt;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                   fault_q;
  assign FetchFault = fault_q;
`endif

  // Reset gates the strobe so no request leaves while rst is held.
  assign imem.ImemReq  = (state_q == S_REQ) && !rst;
  assign imem.ImemAddr = pcf_q;
  assign InstrD        = instr_q;
  assign PCD           = pcd_q;
  assign PCPlus4D      = pcp4_q;
  assign ValidD        = vld_q;

  always_comb begin
    tgt      = PCTarget & ALIGN_MASK;
    misalign = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign = PCSrc && (PCTarget[1:0] != 2'b00);
`endif
    state_d = state_q;
    pcf_d   = pcf_q;
    buf_d   = buf_q;
    deliver = 1'b0;
    dword   = buf_q;
    case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
        if (PCSrc) begin
          pcf_d   = tgt;
          state_d = S_DROP;
        end
      end
      S_WAIT: begin
        if (PCSrc) begin
          pcf_d   = tgt;
          state_d = imem.ImemValid ? S_REQ : S_DROP;
        end else if (imem.ImemValid) begin
          if (Stall) begin
            buf_d   = imem.ImemRdata;
            state_d = S_FULL;
          end else begin
            deliver = 1'b1;
            dword   = imem.ImemRdata;
          end
        end
      end
      S_FULL: begin
        if (PCSrc) begin
          pcf_d   = tgt;
          state_d = S_REQ;
        end else if (!Stall) begin
          deliver = 1'b1;
        end
      end
      S_DROP: begin
        // A second redirect here still owes one stale beat, unless it is arriving now.
        if (PCSrc) pcf_d = tgt;
        if (imem.ImemValid) state_d = S_REQ;
      end
      default: state_d = S_HALT;
    endcase
    if (deliver) begin
      pcf_d   = pcf_q + FOUR;
      state_d = S_REQ;
    end
    if (misalign) state_d = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pcf_q   <= RESET_PC;
      buf_q   <= '0;
      instr_q <= NOP;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      vld_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      buf_q   <= buf_d;
      // Flush beats a stall; a delivered word lost to Flush is always paired with a redirect.
      if (Flush || state_q == S_HALT) begin
        instr_q <= NOP;
        vld_q   <= 1'b0;
      end else if (!Stall) begin
        if (deliver) begin
          instr_q <= dword;
          pcd_q   <= pcf_q;
          pcp4_q  <= pcf_q + FOUR;
          vld_q   <= 1'b1;
        end else begin
          instr_q <= NOP;
          vld_q   <= 1'b0;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if (misalign) fault_q <= 1'b1;
`endif
    end
  end
endmodule
